// File: rtl/serial_lane_sender_pkg.sv
// Shared types and helpers for the multi-lane serial packet sender.
package serial_lane_sender_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK
  } sender_state_t;

  localparam logic [3:0] DEFAULT_SYNC_PATTERN = 4'b1110;

  function automatic int lane_bits(input int pkt, input int lanes);
    return pkt / lanes;
  endfunction

endpackage

// File: rtl/serial_lane_sender_if.sv
// Payload/ACK handshake and serial pin bundle between game logic, sender and GPIO.
interface serial_lane_sender_if #(
  parameter int N_LANES    = 4,
  parameter int PKT_BITS   = 64,
  parameter int SEQ_BITS   = 1,
  parameter int RETRY_BITS = 2
);

  logic                  pkt_valid;
  logic [PKT_BITS-1:0]   pkt_data;
  logic                  pkt_ready;
  logic                  ack_valid;
  logic [SEQ_BITS-1:0]   ack_seq;
  logic                  serial_h;
  logic [N_LANES-1:0]    serial_d;
  logic [SEQ_BITS-1:0]   seq_num;
  logic [RETRY_BITS-1:0] retry_cnt;
  logic                  busy;
  logic                  send_done;
  logic                  send_fail;

  modport master (
    output pkt_valid, pkt_data, ack_valid, ack_seq,
    input  pkt_ready, serial_h, serial_d, seq_num, retry_cnt, busy, send_done, send_fail
  );

  modport slave (
    input  pkt_valid, pkt_data, ack_valid, ack_seq,
    output pkt_ready, serial_h, serial_d, seq_num, retry_cnt, busy, send_done, send_fail
  );

endinterface

// File: rtl/serial_lane_sender_lane_shift_reg.sv
// One serial lane: parallel-loaded frame image shifted out MSB first, one bit per shift.
module serial_lane_sender_lane_shift_reg #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  output logic             q
);

  logic [WIDTH-1:0] frame_sr;

  // q is the registered pin level; it only moves on shift so every bit holds a full tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_sr <= '0;
      q        <= 1'b0;
    end else if (clear) begin
      frame_sr <= '0;
      q        <= 1'b0;
    end else if (load) begin
      frame_sr <= load_data;
      q        <= 1'b0;
    end else if (shift) begin
      q        <= frame_sr[WIDTH-1];
      frame_sr <= {frame_sr[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/serial_lane_sender.sv
// Multi-lane serial packet sender: frames a buffered payload onto a header lane plus
// N_LANES data lanes and retransmits on ACK timeout until the retry limit is reached.
module serial_lane_sender
  import serial_lane_sender_pkg::*;
#(
  parameter int                   N_LANES       = 4,
  parameter int                   PKT_BITS      = 64,
  parameter int                   SEQ_BITS      = 1,
  parameter int                   SYNC_BITS     = 4,
  parameter logic [SYNC_BITS-1:0] SYNC_PATTERN  = SYNC_BITS'(DEFAULT_SYNC_PATTERN),
  parameter int                   TIMEOUT_TICKS = 1000,
  parameter int                   MAX_RETRY     = 3
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 bit_tick,
  serial_lane_sender_if.slave bus
);

  localparam int LANE_BITS  = lane_bits(PKT_BITS, N_LANES);
  localparam int FRAME_BITS = SYNC_BITS + SEQ_BITS + LANE_BITS;
  localparam int CNT_BITS   = $clog2(FRAME_BITS + 1);
  localparam int TIMER_BITS = $clog2(TIMEOUT_TICKS + 1);
  localparam int RETRY_BITS = $clog2(MAX_RETRY + 1);

  sender_state_t         state, state_next;
  logic [PKT_BITS-1:0]   pkt_buf;
  logic [PKT_BITS-1:0]   payload_src;
  logic [CNT_BITS-1:0]   bit_cnt;
  logic [TIMER_BITS-1:0] timer;
  logic [RETRY_BITS-1:0] retry_cnt;
  logic [SEQ_BITS-1:0]   seq_num;
  logic                  send_done, send_fail;
  logic                  accept, load, shift, clear, resend, ack_hit, give_up;
  logic                  header_q;
  logic [N_LANES-1:0]    lane_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The matching ACK is tested before the timeout, so it wins when both land in one clk.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    clear      = 1'b0;
    resend     = 1'b0;
    ack_hit    = 1'b0;
    give_up    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.pkt_valid) begin
          accept     = 1'b1;
          load       = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (bit_tick) begin
          if (bit_cnt == CNT_BITS'(FRAME_BITS)) begin
            clear      = 1'b1;
            state_next = WAIT_ACK;
          end else begin
            shift = 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        if (bus.ack_valid && (bus.ack_seq == seq_num)) begin
          ack_hit    = 1'b1;
          state_next = IDLE;
        end else if (bit_tick && (timer == TIMER_BITS'(TIMEOUT_TICKS - 1))) begin
          if (retry_cnt < RETRY_BITS'(MAX_RETRY)) begin
            resend     = 1'b1;
            load       = 1'b1;
            state_next = SEND;
          end else begin
            give_up    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_buf   <= '0;
      bit_cnt   <= '0;
      timer     <= '0;
      retry_cnt <= '0;
      seq_num   <= '0;
      send_done <= 1'b0;
      send_fail <= 1'b0;
    end else begin
      send_done <= ack_hit;
      send_fail <= give_up;
      if (accept) begin
        pkt_buf   <= bus.pkt_data;
        retry_cnt <= '0;
      end else if (resend) begin
        retry_cnt <= retry_cnt + 1'b1;
      end
      if (load)       bit_cnt <= '0;
      else if (shift) bit_cnt <= bit_cnt + 1'b1;
      if (clear)                              timer <= '0;
      else if (state == WAIT_ACK && bit_tick) timer <= timer + 1'b1;
      if (ack_hit) seq_num <= seq_num + 1'b1;
    end
  end

  // On acceptance the buffer is not yet written, so frame images come straight from the bus.
  assign payload_src = accept ? bus.pkt_data : pkt_buf;

  serial_lane_sender_lane_shift_reg #(.WIDTH(FRAME_BITS)) u_header (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .shift     (shift),
    .clear     (clear),
    .load_data ({SYNC_PATTERN, seq_num, {LANE_BITS{1'b0}}}),
    .q         (header_q)
  );

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    serial_lane_sender_lane_shift_reg #(.WIDTH(FRAME_BITS)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .shift     (shift),
      .clear     (clear),
      .load_data ({{(SYNC_BITS + SEQ_BITS){1'b0}}, payload_src[(i+1)*LANE_BITS-1 -: LANE_BITS]}),
      .q         (lane_q[i])
    );
  end

  assign bus.pkt_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.serial_h  = header_q;
  assign bus.serial_d  = lane_q;
  assign bus.seq_num   = seq_num;
  assign bus.retry_cnt = retry_cnt;
  assign bus.send_done = send_done;
  assign bus.send_fail = send_fail;

endmodule

// File: tb/tb_serial_lane_sender.sv
// Scoreboard bench for serial_lane_sender: stimulus queues expected frames and outcomes,
// a negedge monitor reassembles frames from the pins and pops/compares them.
module tb_serial_lane_sender;

  localparam int TIMEOUT   = 8;
  localparam int MAX_RETRY = 2;

  typedef struct packed {
    logic [15:0][4:0] bits;
    logic [4:0]       len;
    logic [1:0]       retry;
  } frame_t;

  typedef struct packed {
    logic       fail;
    logic [1:0] seq;
    logic [1:0] retry;
  } outcome_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_tick = 1'b0;
  logic        pv = 1'b0;
  logic        av = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] pd = '0;
  logic [1:0]  ack_s = '0;
  int          errors = 0;
  int          checks = 0;
  int          model_seq = 0;
  int          gap_mode = 0;
  frame_t      exp_frames[$];
  outcome_t    exp_out[$];

  serial_lane_sender_if #(.N_LANES(4), .PKT_BITS(16), .SEQ_BITS(1), .RETRY_BITS(2)) bus1 ();
  serial_lane_sender_if #(.N_LANES(4), .PKT_BITS(16), .SEQ_BITS(2), .RETRY_BITS(2)) bus2 ();

  assign bus1.pkt_valid = pv & ~sel;
  assign bus1.pkt_data  = pd;
  assign bus1.ack_valid = av & ~sel;
  assign bus1.ack_seq   = ack_s[0];
  assign bus2.pkt_valid = pv & sel;
  assign bus2.pkt_data  = pd;
  assign bus2.ack_valid = av & sel;
  assign bus2.ack_seq   = ack_s;

  serial_lane_sender #(
    .N_LANES(4), .PKT_BITS(16), .SEQ_BITS(1), .SYNC_BITS(4), .SYNC_PATTERN(4'b1110),
    .TIMEOUT_TICKS(TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut1 (.clk(clk), .rst(rst), .bit_tick(bit_tick), .bus(bus1));

  serial_lane_sender #(
    .N_LANES(4), .PKT_BITS(16), .SEQ_BITS(2), .SYNC_BITS(4), .SYNC_PATTERN(4'b1110),
    .TIMEOUT_TICKS(TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut2 (.clk(clk), .rst(rst), .bit_tick(bit_tick), .bus(bus2));

  always #10 clk = ~clk;

  logic       m_h, m_busy, m_ready, m_done, m_fail;
  logic [3:0] m_d;
  logic [1:0] m_seq, m_retry;

  always_comb begin
    if (sel) begin
      m_h = bus2.serial_h;  m_d = bus2.serial_d;  m_seq = bus2.seq_num;
      m_retry = bus2.retry_cnt;  m_busy = bus2.busy;  m_ready = bus2.pkt_ready;
      m_done = bus2.send_done;  m_fail = bus2.send_fail;
    end else begin
      m_h = bus1.serial_h;  m_d = bus1.serial_d;  m_seq = {1'b0, bus1.seq_num};
      m_retry = bus1.retry_cnt;  m_busy = bus1.busy;  m_ready = bus1.pkt_ready;
      m_done = bus1.send_done;  m_fail = bus1.send_fail;
    end
  end

  function automatic int seqBits();
    return sel ? 2 : 1;
  endfunction

  function automatic int frameLen();
    return 8 + seqBits();
  endfunction

  // Reference frame: sync preamble, seq MSB first, then each lane's nibble MSB first.
  function automatic frame_t makeFrame(input logic [15:0] data, input int seq, input int sb,
                                       input int retry);
    frame_t     f;
    logic [3:0] sync;
    logic       h;
    logic [3:0] d;
    sync    = 4'b1110;
    f       = '0;
    f.len   = 5'(8 + sb);
    f.retry = 2'(retry);
    for (int k = 0; k < 8 + sb; k++) begin
      if (k < 4)           h = sync[3-k];
      else if (k < 4 + sb) h = seq[sb-1-(k-4)];
      else                 h = 1'b0;
      for (int i = 0; i < 4; i++)
        d[i] = (k < 4 + sb) ? 1'b0 : data[i*4 + 3 - (k-4-sb)];
      f.bits[k] = {h, d};
    end
    return f;
  endfunction

  function automatic outcome_t mkOut(input logic fail, input int seq, input int retry);
    outcome_t o;
    o.fail  = fail;
    o.seq   = 2'(seq);
    o.retry = 2'(retry);
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [79:0] actual,
                             input logic [79:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  logic   tick_q = 1'b0;
  frame_t cap = '0;
  int     cap_n = 0;
  bit     capturing = 1'b0;

  always @(posedge clk) tick_q <= bit_tick;

  task automatic checkFrame();
    frame_t e;
    if (exp_frames.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_frame: got %0h expected none", cap.bits);
    end else begin
      e = exp_frames.pop_front();
      checkOutput("frame_bits", 80'(cap.bits), 80'(e.bits));
      checkOutput("frame_retry", 80'(cap.retry), 80'(e.retry));
    end
  endtask

  task automatic checkOutcome();
    outcome_t o;
    if (exp_out.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_outcome: got done=%0b fail=%0b expected none", m_done, m_fail);
    end else begin
      o = exp_out.pop_front();
      checkOutput("outcome_fail", 80'(m_fail), 80'(o.fail));
      checkOutput("outcome_done", 80'(m_done), 80'(!o.fail));
      checkOutput("outcome_seq", 80'(m_seq), 80'(o.seq));
      checkOutput("outcome_retry", 80'(m_retry), 80'(o.retry));
      checkOutput("outcome_ready", 80'(m_ready), 80'(1));
    end
  endtask

  // Pins only move on the clk after a bit_tick; every other clk they must hold.
  always @(negedge clk) begin
    if (rst) begin
      capturing = 1'b0;
    end else begin
      if (m_done || m_fail) checkOutcome();
      if (tick_q) begin
        if (capturing && cap_n < frameLen()) begin
          cap.bits[cap_n] = {m_h, m_d};
          cap_n++;
        end else if (capturing) begin
          checkOutput("frame_tail_idle", 80'({m_h, m_d}), 80'(0));
          checkFrame();
          capturing = 1'b0;
        end else if (m_h) begin
          cap         = '0;
          cap.len     = 5'(frameLen());
          cap.retry   = m_retry;
          cap.bits[0] = {m_h, m_d};
          cap_n       = 1;
          capturing   = 1'b1;
        end
      end else if (capturing) begin
        checkOutput("bit_hold", 80'({m_h, m_d}), 80'(cap.bits[cap_n-1]));
      end
    end
  end

  task automatic issueTicks(input int n);
    for (int k = 0; k < n; k++) begin
      bit_tick = 1'b1;
      @(negedge clk);
      bit_tick = 1'b0;
      repeat (gap_mode != 0 ? $urandom_range(2, 0) : 0) @(negedge clk);
    end
  endtask

  task automatic ackPhase(input int attempt, input int style, input int sb);
    int nxt;
    nxt = (model_seq + 1) % (1 << sb);
    case (style)
      1: begin
        ack_s = 2'(nxt);
        av    = 1'b1;
        @(negedge clk);
        av = 1'b0;
        issueTicks(2);
        checkOutput("wrong_ack_busy", 80'(m_busy), 80'(1));
        exp_out.push_back(mkOut(1'b0, nxt, attempt));
        ack_s = 2'(model_seq);
        av    = 1'b1;
        @(negedge clk);
        av = 1'b0;
      end
      2: begin
        issueTicks(TIMEOUT - 1);
        exp_out.push_back(mkOut(1'b0, nxt, attempt));
        ack_s    = 2'(model_seq);
        av       = 1'b1;
        bit_tick = 1'b1;
        @(negedge clk);
        av       = 1'b0;
        bit_tick = 1'b0;
      end
      default: begin
        issueTicks($urandom_range(TIMEOUT - 1, 0));
        exp_out.push_back(mkOut(1'b0, nxt, attempt));
        ack_s = 2'(model_seq);
        av    = 1'b1;
        @(negedge clk);
        av = 1'b0;
      end
    endcase
    model_seq = nxt;
  endtask

  // n_timeouts > MAX_RETRY means the packet is never ACKed and must fail.
  task automatic applyStimulus(input logic [15:0] data, input int n_timeouts, input int style);
    int  sb;
    int  len;
    bit  finished;
    sb       = seqBits();
    len      = frameLen();
    finished = 1'b0;
    pd = data;
    pv = 1'b1;
    @(negedge clk);
    pd = ~data;
    for (int a = 0; a <= MAX_RETRY && !finished; a++) begin
      exp_frames.push_back(makeFrame(data, model_seq, sb, a));
      issueTicks(len + 1);
      pv = 1'b0;
      if (a == n_timeouts) begin
        ackPhase(a, style, sb);
        finished = 1'b1;
      end else begin
        if (a == MAX_RETRY) exp_out.push_back(mkOut(1'b1, model_seq, a));
        issueTicks(TIMEOUT);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int exp_wrap[4];
    exp_wrap = '{1, 2, 3, 0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_serial_h", 80'(m_h), 80'(0));
    checkOutput("reset_serial_d", 80'(m_d), 80'(0));
    checkOutput("reset_seq", 80'(m_seq), 80'(0));
    checkOutput("reset_retry", 80'(m_retry), 80'(0));
    checkOutput("reset_ready", 80'(m_ready), 80'(1));
    checkOutput("reset_busy", 80'(m_busy), 80'(0));
    checkOutput("reset_done", 80'(m_done), 80'(0));
    checkOutput("reset_fail", 80'(m_fail), 80'(0));

    applyStimulus(16'hA5C3, 0, 0);
    checkOutput("first_ack_seq", 80'(m_seq), 80'(1));
    gap_mode = 1;
    applyStimulus(16'($urandom), 3, 0);
    checkOutput("fail_seq_kept", 80'(m_seq), 80'(1));
    checkOutput("fail_retry_held", 80'(m_retry), 80'(2));
    checkOutput("fail_idle", 80'(m_busy), 80'(0));
    applyStimulus(16'($urandom), 0, 1);
    applyStimulus(16'($urandom), 0, 2);
    applyStimulus(16'($urandom), 1, 2);

    for (int n = 0; n < 12; n++) begin
      gap_mode = int'($urandom_range(1, 0));
      applyStimulus(16'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
    end

    if (model_seq == 0) applyStimulus(16'($urandom), 0, 0);
    pd = 16'($urandom);
    pv = 1'b1;
    @(negedge clk);
    pv = 1'b0;
    issueTicks(5);
    exp_frames.delete();
    exp_out.delete();
    #2 rst = 1'b1;
    #1;
    checkOutput("midframe_rst_h", 80'(m_h), 80'(0));
    checkOutput("midframe_rst_d", 80'(m_d), 80'(0));
    checkOutput("midframe_rst_seq", 80'(m_seq), 80'(0));
    checkOutput("midframe_rst_ready", 80'(m_ready), 80'(1));
    model_seq = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    applyStimulus(16'h3C5A, 0, 0);

    sel       = 1'b1;
    model_seq = 0;
    gap_mode  = 0;
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      applyStimulus(16'($urandom), 0, int'($urandom_range(2, 0)));
      checkOutput("seq2_wrap", 80'(m_seq), 80'(exp_wrap[n]));
    end

    repeat (4) @(negedge clk);
    checkOutput("pending_frames", 80'(exp_frames.size()), 80'(0));
    checkOutput("pending_outcomes", 80'(exp_out.size()), 80'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
